// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: latches MEM results, selects the write-back value,
// and drives the register-file write port plus a one-hot per-row write enable.
module mem_wb_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic                  in_RegWrite,
  input  logic                  in_MemtoReg,
  input  logic                  in_PCS,
  input  logic                  in_halt,
  input  logic [REG_AW-1:0]     in_dst_reg,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [DATA_W-1:0]     in_mem_data,
  input  logic [DATA_W-1:0]     in_pc_plus2,
  output logic                  wb_valid,
  output logic                  wb_we,
  output logic [REG_AW-1:0]     wb_reg,
  output logic [DATA_W-1:0]     wb_data,
  output logic [2**REG_AW-1:0]  wb_we_onehot,
  output logic                  halted,
  output logic [CNT_W-1:0]      retire_count
);

  localparam int NREG = 2**REG_AW;

  logic              valid_q;
  logic              regwrite_q;
  logic              halt_q;
  logic              halted_q;
  logic [REG_AW-1:0] reg_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic [CNT_W-1:0]  cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // PC+2 (link) outranks load data, which outranks the ALU result.
  always_comb begin
    data_d = in_alu_result;
    if (in_PCS)
      data_d = in_pc_plus2;
    else if (in_MemtoReg)
      data_d = in_mem_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      halt_q     <= 1'b0;
      halted_q   <= 1'b0;
      reg_q      <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
    end else if (!halted_q) begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (!stall) begin
        valid_q    <= in_valid;
        regwrite_q <= in_RegWrite;
        halt_q     <= in_halt;
        reg_q      <= in_dst_reg;
        data_q     <= data_d;
        if (in_valid) begin
          cnt_q <= sat_inc(cnt_q);
          if (in_halt)
            halted_q <= 1'b1;
        end
      end
    end
  end

  // R0 is hardwired zero and HLT never writes, so both suppress the enable.
  assign wb_we = valid_q & regwrite_q & (reg_q != '0) & ~halt_q;

  always_comb begin
    wb_we_onehot = '0;
    if (wb_we)
      wb_we_onehot[reg_q] = 1'b1;
  end

  assign wb_valid     = valid_q;
  assign wb_reg       = reg_q;
  assign wb_data      = data_q;
  assign halted       = halted_q;
  assign retire_count = cnt_q;

  logic unused_ok;
  assign unused_ok = ^NREG;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized and directed bench for mem_wb_stage against a behavioural model;
// a second instance with a 4-bit counter exercises saturation.
module tb_mem_wb_stage;
  localparam int DATA_W = 16;
  localparam int REG_AW = 4;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall, flush, in_valid, in_RegWrite, in_MemtoReg, in_PCS, in_halt;
  logic [REG_AW-1:0] in_dst_reg;
  logic [DATA_W-1:0] in_alu_result, in_mem_data, in_pc_plus2;

  logic              wb_valid, wb_we, halted;
  logic [REG_AW-1:0] wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic [15:0]       wb_we_onehot;
  logic [CNT_W-1:0]  retire_count;

  logic              s_wb_valid, s_wb_we, s_halted;
  logic [REG_AW-1:0] s_wb_reg;
  logic [DATA_W-1:0] s_wb_data;
  logic [15:0]       s_wb_we_onehot;
  logic [3:0]        s_retire_count;

  mem_wb_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_RegWrite(in_RegWrite), .in_MemtoReg(in_MemtoReg), .in_PCS(in_PCS),
    .in_halt(in_halt), .in_dst_reg(in_dst_reg), .in_alu_result(in_alu_result),
    .in_mem_data(in_mem_data), .in_pc_plus2(in_pc_plus2),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .wb_we_onehot(wb_we_onehot), .halted(halted), .retire_count(retire_count));

  mem_wb_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_RegWrite(in_RegWrite), .in_MemtoReg(in_MemtoReg), .in_PCS(in_PCS),
    .in_halt(in_halt), .in_dst_reg(in_dst_reg), .in_alu_result(in_alu_result),
    .in_mem_data(in_mem_data), .in_pc_plus2(in_pc_plus2),
    .wb_valid(s_wb_valid), .wb_we(s_wb_we), .wb_reg(s_wb_reg), .wb_data(s_wb_data),
    .wb_we_onehot(s_wb_we_onehot), .halted(s_halted), .retire_count(s_retire_count));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: what WB holds, in instruction-level terms.
  bit         m_valid, m_rw, m_hlt, m_halted, m_known;
  int         m_reg, m_data, m_cnt;

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_hlt = 0; m_halted = 0; m_known = 1;
    m_reg = 0; m_data = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    if (m_halted) return;
    if (flush) begin
      m_valid = 0; m_known = 0;
    end else if (!stall) begin
      m_valid = in_valid; m_rw = in_RegWrite; m_hlt = in_halt;
      m_reg = int'(in_dst_reg); m_known = 1;
      if (in_PCS)           m_data = int'(in_pc_plus2);
      else if (in_MemtoReg) m_data = int'(in_mem_data);
      else                  m_data = int'(in_alu_result);
      if (in_valid) begin
        m_cnt++;
        if (in_halt) m_halted = 1;
      end
    end
  endtask

  task automatic check_all();
    bit exp_we;
    int exp_oh;
    exp_we = m_valid && m_rw && (m_reg != 0) && !m_hlt;
    exp_oh = exp_we ? (1 << m_reg) : 0;
    chk("wb_valid", 32'(wb_valid), 32'(m_valid));
    chk("wb_we", 32'(wb_we), 32'(exp_we));
    chk("onehot", 32'(wb_we_onehot), 32'(exp_oh));
    chk("halted", 32'(halted), 32'(m_halted));
    chk("count", 32'(retire_count), 32'((m_cnt > 65535) ? 65535 : m_cnt));
    chk("count_sat", 32'(s_retire_count), 32'((m_cnt > 15) ? 15 : m_cnt));
    if (m_known) begin
      chk("wb_reg", 32'(wb_reg), 32'(m_reg));
      chk("wb_data", 32'(wb_data), 32'(m_data));
    end
  endtask

  task automatic set_in(input bit v, input bit rw, input bit m2r, input bit pcs,
                        input bit h, input int dst, input int alu, input int mem,
                        input int pc, input bit st, input bit fl);
    in_valid = v; in_RegWrite = rw; in_MemtoReg = m2r; in_PCS = pcs; in_halt = h;
    in_dst_reg = REG_AW'(dst); in_alu_result = DATA_W'(alu);
    in_mem_data = DATA_W'(mem); in_pc_plus2 = DATA_W'(pc);
    stall = st; flush = fl;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Asserts reset mid-cycle and checks outputs clear before the next edge.
  task automatic async_reset();
    #3;
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(wb_valid), 0);
    chk("rst_we", 32'(wb_we), 0);
    chk("rst_reg", 32'(wb_reg), 0);
    chk("rst_data", 32'(wb_data), 0);
    chk("rst_onehot", 32'(wb_we_onehot), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_count", 32'(retire_count), 0);
    chk("rst_count_sat", 32'(s_retire_count), 0);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();

    // ALU write
    set_in(1, 1, 0, 0, 0, 5, 'h1234, 'h5555, 'h0002, 0, 0);
    cycle();
    chk("alu_data", 32'(wb_data), 32'h1234);
    chk("alu_onehot", 32'(wb_we_onehot), 32'h0020);
    chk("alu_count", 32'(retire_count), 1);

    // Mux priority and R0 suppression
    set_in(1, 1, 1, 0, 0, 6, 'h1111, 'hBEEF, 'h0040, 0, 0);
    cycle();
    chk("mem_data", 32'(wb_data), 32'hBEEF);
    set_in(1, 1, 1, 1, 0, 6, 'h1111, 'hBEEF, 'h0042, 0, 0);
    cycle();
    chk("pcs_data", 32'(wb_data), 32'h0042);
    set_in(1, 1, 0, 0, 0, 0, 'h7777, 'h0, 'h0, 0, 0);
    cycle();
    chk("r0_we", 32'(wb_we), 0);
    chk("r0_onehot", 32'(wb_we_onehot), 0);

    // Stall holds, flush beats stall
    set_in(1, 1, 0, 0, 0, 3, 'h00AA, 0, 0, 0, 0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 0, 0, 0, 9 + i, 'h1000 + i, 0, 0, 1, 0);
      cycle();
      chk("stall_data", 32'(wb_data), 32'h00AA);
      chk("stall_we", 32'(wb_we), 1);
    end
    set_in(1, 1, 0, 0, 0, 4, 'h2222, 0, 0, 1, 1);
    cycle();
    chk("flush_valid", 32'(wb_valid), 0);
    chk("flush_we", 32'(wb_we), 0);

    // Mid-cycle reset with valid WB contents
    set_in(1, 1, 0, 0, 0, 2, 'h3333, 0, 0, 0, 0);
    cycle();
    async_reset();

    // HLT freezes everything until reset
    set_in(1, 1, 0, 0, 1, 7, 'h4444, 0, 0, 0, 0);
    cycle();
    chk("hlt_halted", 32'(halted), 1);
    chk("hlt_we", 32'(wb_we), 0);
    chk("hlt_count", 32'(retire_count), 1);
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 0, 0, 0, 1 + i, 'h5000 + i, 0, 0, 0, 0);
      cycle();
    end
    chk("hlt_frozen_count", 32'(retire_count), 1);
    async_reset();
    set_in(1, 1, 0, 0, 1, 7, 'h4444, 0, 0, 0, 1);
    cycle();
    chk("hlt_flush_halted", 32'(halted), 0);

    // Counter saturation on the 4-bit instance
    async_reset();
    for (int i = 0; i < 20; i++) begin
      set_in(1, 1, 0, 0, 0, i % 16, i * 3, 0, 0, 0, 0);
      cycle();
    end
    chk("sat15", 32'(s_retire_count), 15);
    chk("cnt20", 32'(retire_count), 20);

    // Randomized rounds
    for (int r = 0; r < 6; r++) begin
      async_reset();
      for (int c = 0; c < 80; c++) begin
        set_in($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
               $urandom_range(0, 49) == 0, int'($urandom_range(0, 15)),
               int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
               int'($urandom_range(0, 65535)),
               $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
        cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
